// File: rtl/cmd_bus_tx.sv
// cmd_bus_tx - transmit end of the 3-bit strobed command bus (strobe + C2..C0).
//
// Accepts one opcode per valid/ready handshake and expands it into its symbol
// sequence. Each symbol is driven with a setup/high/hold envelope long enough to
// pass the far-end input filters; the far end samples bus_c on the falling edge
// of bus_clk. A command ends with an idle gap, after which done pulses.
//
// Ports
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   cmd_valid  in   opcode request
//   cmd_op     in   opcode (0..8 legal, 9..15 illegal)
//   cmd_ready  out  high only while idle
//   busy       out  high while a legal command is in flight
//   done       out  1-cycle pulse on the first idle cycle after a command's gap
//   cmd_err    out  1-cycle pulse in the cycle after an illegal opcode is accepted
//   bus_clk    out  strobe to far-end CLK
//   bus_c      out  symbol to far-end C2..C0
//
// All outputs come straight from flops; their next values are decoded from the
// next state, so nothing combinational reaches the pins.
module cmd_bus_tx #(
  parameter int T_SETUP = 32,
  parameter int T_HIGH  = 64,
  parameter int T_HOLD  = 64,
  parameter int T_GAP   = 128,
  parameter int CW      = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_op,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic       bus_clk,
  output logic [2:0] bus_c
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_e;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_HIGH  = CW'(T_HIGH - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

  // Number of symbols in an opcode's sequence (only called for legal opcodes).
  function automatic logic [2:0] sym_len(input logic [3:0] op);
    case (op)
      4'd0, 4'd5: sym_len = 3'd2;
      4'd7, 4'd8: sym_len = 3'd5;
      default:    sym_len = 3'd1;
    endcase
  endfunction

  // Symbol idx of an opcode's sequence.
  function automatic logic [2:0] sym_at(input logic [3:0] op, input logic [2:0] idx);
    sym_at = 3'd0;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        // single leading symbol equal to the opcode; START's trailing symbol is 0
        if (idx == 3'd0) sym_at = op[2:0];
      end
      4'd7, 4'd8: begin
        // discharge: 7,0,7,0 then a variant-specific tail symbol
        case (idx)
          3'd0, 3'd2: sym_at = 3'd7;
          3'd4:       sym_at = (op == 4'd7) ? 3'd1 : 3'd3;
          default:    sym_at = 3'd0;
        endcase
      end
      default: sym_at = 3'd0;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    op_q, op_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          bclk_q, bclk_d;
  logic [2:0]    bc_q, bc_d;
  logic          cnt_zero;
  logic          last_sym;
  logic          in_sym;

  assign cnt_zero = (cnt_q == '0);
  assign last_sym = (idx_q == (sym_len(op_q) - 3'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    op_d    = op_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // cmd_ready is always high here, so cmd_valid alone means accept
        if (cmd_valid) begin
          if (cmd_op <= 4'd8) begin
            state_d = S_SETUP;
            cnt_d   = LD_SETUP;
            idx_d   = 3'd0;
            op_d    = cmd_op;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: if (cnt_zero) begin
        state_d = S_HIGH;
        cnt_d   = LD_HIGH;
      end
      S_HIGH: if (cnt_zero) begin
        state_d = S_HOLD;
        cnt_d   = LD_HOLD;
      end
      S_HOLD: if (cnt_zero) begin
        if (last_sym) begin
          state_d = S_GAP;
          cnt_d   = LD_GAP;
        end else begin
          // index only advances when another symbol exists, so it cannot overrun
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
          idx_d   = idx_q + 3'd1;
        end
      end
      S_GAP: if (cnt_zero) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they describe. bus_c is only loaded on SETUP entry and
    // stays constant through HIGH and HOLD.
    in_sym  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_HOLD);
    bc_d    = in_sym ? sym_at(op_d, idx_d) : 3'd0;
    bclk_d  = (state_d == S_HIGH);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      op_q    <= 4'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bclk_q  <= 1'b0;
      bc_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bclk_q  <= bclk_d;
      bc_q    <= bc_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = err_q;
  assign bus_clk   = bclk_q;
  assign bus_c     = bc_q;

endmodule

// File: tb/tb_cmd_bus_tx.sv
// tb_cmd_bus_tx - self-checking bench for cmd_bus_tx.
// Expected pin values per cycle are computed arithmetically from the symbol
// table and the setup/high/hold/gap durations; a far-end model (16-tap filters
// plus falling-edge sampler) decodes each legal command back to its opcode.
module tb_cmd_bus_tx;

  localparam int T_SETUP = 32;
  localparam int T_HIGH  = 64;
  localparam int T_HOLD  = 64;
  localparam int T_GAP   = 128;
  localparam int S       = T_SETUP + T_HIGH + T_HOLD;
  // {cmd_ready, busy, done, cmd_err, bus_clk, bus_c[2:0]}
  localparam logic [7:0] IDLE_VEC = 8'b1000_0000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_op = 4'd0;
  logic       cmd_ready, busy, done, cmd_err, bus_clk;
  logic [2:0] bus_c;

  cmd_bus_tx #(
    .T_SETUP(T_SETUP), .T_HIGH(T_HIGH), .T_HOLD(T_HOLD), .T_GAP(T_GAP), .CW(16)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .cmd_err(cmd_err),
    .bus_clk(bus_clk), .bus_c(bus_c)
  );

  always #5 clk = ~clk;

  // Symbol table of the command set
  int         seq_len [9] = '{2, 1, 1, 1, 1, 2, 1, 5, 5};
  logic [2:0] seq_tab [9][5] = '{
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd6, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd7, 3'd0, 3'd7, 3'd0, 3'd1},
    '{3'd7, 3'd0, 3'd7, 3'd0, 3'd3}
  };

  int n_cmp = 0;
  int n_bad = 0;

  // Far-end receiver: a line changes only after 16 equal samples; the filtered
  // symbol is captured on each filtered falling edge of the strobe.
  logic [15:0] h_clk = '0, h_c0 = '0, h_c1 = '0, h_c2 = '0;
  logic        f_clk = 1'b0;
  logic [2:0]  f_c = 3'd0;
  logic [2:0]  rx_q[$];

  always @(posedge clk) begin
    h_clk <= {h_clk[14:0], bus_clk};
    h_c0  <= {h_c0[14:0], bus_c[0]};
    h_c1  <= {h_c1[14:0], bus_c[1]};
    h_c2  <= {h_c2[14:0], bus_c[2]};
    if (&h_clk) f_clk <= 1'b1;
    else if (h_clk == 16'h0) begin
      if (f_clk) rx_q.push_back(f_c);
      f_clk <= 1'b0;
    end
    if (&h_c0) f_c[0] <= 1'b1; else if (h_c0 == 16'h0) f_c[0] <= 1'b0;
    if (&h_c1) f_c[1] <= 1'b1; else if (h_c1 == 16'h0) f_c[1] <= 1'b0;
    if (&h_c2) f_c[2] <= 1'b1; else if (h_c2 == 16'h0) f_c[2] <= 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {cmd_ready, busy, done, cmd_err, bus_clk, bus_c};
  endfunction

  // Expected pins t cycles after the accept edge (t=0 is the first cycle after it).
  function automatic logic [7:0] exp_vec(input int op, input int t);
    int  kn, k, w;
    logic ck;
    if (op > 8) return (t == 0) ? 8'b1001_0000 : IDLE_VEC;
    kn = seq_len[op];
    if (t < kn * S) begin
      k  = t / S;
      w  = t % S;
      ck = (w >= T_SETUP) && (w < T_SETUP + T_HIGH);
      return {1'b0, 1'b1, 1'b0, 1'b0, ck, seq_tab[op][k]};
    end
    if (t < kn * S + T_GAP) return 8'b0100_0000;
    return 8'b1010_0000;
  endfunction

  // Map the received symbol list back to an opcode, -1 if it matches none.
  function automatic int decode_rx();
    for (int o = 0; o < 9; o++) begin
      if (rx_q.size() == seq_len[o]) begin
        bit m = 1'b1;
        for (int i = 0; i < seq_len[o]; i++)
          if (rx_q[i] !== seq_tab[o][i]) m = 1'b0;
        if (m) return o;
      end
    end
    return -1;
  endfunction

  // Raise a request, wait for the accept edge, then check every cycle up to the
  // done cycle (or 500 cycles for an illegal opcode). With hold_next the request
  // stays asserted carrying next_op so the following call sees back-to-back.
  task automatic run_cmd(input int op, input bit hold_next, input int next_op,
                         input int exp_wait, input string tag);
    int   waited, last;
    bit   ok;
    logic r;
    rx_q.delete();
    cmd_valid = 1'b1;
    cmd_op    = 4'(op);
    waited    = 0;
    ok        = 1'b0;
    while (!ok && waited < 2000) begin
      r = cmd_ready;
      tick();
      waited++;
      ok = (r === 1'b1);
    end
    chk({tag, ":accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    chk({tag, ":wait"}, 32'(waited), 32'(exp_wait));
    if (hold_next) cmd_op = 4'(next_op);
    else cmd_valid = 1'b0;
    last = (op > 8) ? 500 : seq_len[op] * S + T_GAP;
    for (int t = 0; t <= last; t++) begin
      chk($sformatf("%s:t%0d", tag, t), 32'(obs_vec()), 32'(exp_vec(op, t)));
      if (t < last) tick();
    end
    if (op <= 8) chk({tag, ":decode"}, 32'(decode_rx()), 32'(op));
    else chk({tag, ":rx_empty"}, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r_s;
    int   op, idle;

    // Reset and quiet bus after release
    rstn = 1'b0;
    tick();
    tick();
    chk("reset", 32'(obs_vec()), 32'(IDLE_VEC));
    rstn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk($sformatf("quiet%0d", i), 32'(obs_vec()), 32'(IDLE_VEC));
    end

    // Single-symbol and five-symbol commands
    run_cmd(1, 1'b0, 0, 1, "plus");
    tick();
    run_cmd(7, 1'b0, 0, 1, "disch_a");
    tick();
    run_cmd(8, 1'b0, 0, 1, "disch_b");
    tick();

    // Held request: second accept must land on the done cycle of the first
    run_cmd(0, 1'b1, 5, 1, "b2b_pause");
    run_cmd(5, 1'b0, 0, 1, "b2b_start");
    tick();

    // Illegal opcode
    run_cmd(12, 1'b0, 0, 1, "illegal");
    tick();

    // Reset in the middle of DISCH_A, then a clean SHUTDOWN
    rx_q.delete();
    cmd_valid = 1'b1;
    cmd_op    = 4'd7;
    r_s       = cmd_ready;
    tick();
    chk("mid_rst:accept", 32'(r_s), 32'd1);
    cmd_valid = 1'b0;
    for (int t = 0; t < 119; t++) begin
      chk($sformatf("mid_rst:t%0d", t), 32'(obs_vec()), 32'(exp_vec(7, t)));
      tick();
    end
    rstn = 1'b0;
    #1;
    chk("mid_rst:async", 32'(obs_vec()), 32'(IDLE_VEC));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_rst:hold%0d", i), 32'(obs_vec()), 32'(IDLE_VEC));
    end
    rstn = 1'b1;
    tick();
    chk("mid_rst:release", 32'(obs_vec()), 32'(IDLE_VEC));
    run_cmd(6, 1'b0, 0, 1, "after_rst");

    // Every legal opcode through the far-end decoder
    for (int o = 0; o < 9; o++) begin
      tick();
      run_cmd(o, 1'b0, 0, 1, $sformatf("op%0d", o));
    end

    // Randomized commands with random idle spacing
    for (int n = 0; n < 15; n++) begin
      idle = $urandom_range(3, 1);
      for (int i = 0; i < idle; i++) begin
        tick();
        chk($sformatf("rnd%0d:idle%0d", n, i), 32'(obs_vec()), 32'(IDLE_VEC));
      end
      if ($urandom_range(7, 0) == 0) op = $urandom_range(15, 9);
      else op = $urandom_range(8, 0);
      run_cmd(op, 1'b0, 0, 1, $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
